bo_datapath: RTL and testbench

- Operative block (datapath) driven by the BC control block's control word (LX, LS, LH, H, M0, M1, M2).
- Holds three working registers: X, S and HR.
- Contains two operand muxes and a 4-function ALU, plus registered status flags.
- BC drives the sequencing; this block only executes the control word present at each rising clock edge.

---
 rtl/bc_bo_pkg.sv | 30 +++
 rtl/bo_alu.sv | 52 +++++
 rtl/bo_datapath.sv | 104 ++++++++++
 tb/tb_bo_datapath.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bc_bo_pkg.sv
// ============================================================================
// Module   : bc_bo_pkg
// Brief    : Control-word encodings shared by the BC controller and bo_datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bc_bo_pkg;

  // Operand A select (M0)
  localparam logic [1:0] SEL_XIN = 2'd0;
  localparam logic [1:0] SEL_X   = 2'd1;
  localparam logic [1:0] SEL_S   = 2'd2;
  localparam logic [1:0] SEL_HR  = 2'd3;

  // Operand B select (M1)
  localparam logic [1:0] SELB_X  = 2'd0;
  localparam logic [1:0] SELB_C0 = 2'd1;
  localparam logic [1:0] SELB_C1 = 2'd2;
  localparam logic [1:0] SELB_S  = 2'd3;

  // ALU operation (M2)
  localparam logic [1:0] OP_PASS = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/bo_alu.sv
// ============================================================================
// Module   : bo_alu
// Brief    : Combinational unsigned 4-function ALU with overflow/borrow output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bo_alu
  import bc_bo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [1:0]   i_op,
  output logic [W-1:0] o_y,
  output logic         o_ovf
);

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_prod;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};

  always_comb begin
    o_y   = i_a;
    o_ovf = 1'b0;
    case (i_op)
      OP_PASS: begin
        o_y   = i_a;
        o_ovf = 1'b0;
      end
      OP_ADD: begin
        o_y   = w_sum[W-1:0];
        o_ovf = w_sum[W];
      end
      OP_SUB: begin
        o_y   = i_a - i_b;
        o_ovf = (i_a < i_b);
      end
      default: begin
        // Truncated product overflows when any upper-half bit is set.
        o_y   = w_prod[W-1:0];
        o_ovf = |w_prod[2*W-1:W];
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bo_datapath.sv
// ============================================================================
// Module   : bo_datapath
// Brief    : Operative block executing the BC control word on X, S and HR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bo_datapath
  import bc_bo_pkg::*;
#(
  parameter int W  = 8,
  parameter int C0 = 2,
  parameter int C1 = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x_in,
  input  logic         LX,
  input  logic         LS,
  input  logic         LH,
  input  logic         H,
  input  logic [1:0]   M0,
  input  logic [1:0]   M1,
  input  logic [1:0]   M2,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         ovf,
  output logic         valid,
  output logic [7:0]   op_count
);

  localparam logic [W-1:0] c_c0 = W'(C0);
  localparam logic [W-1:0] c_c1 = W'(C1);

  logic [W-1:0] r_x, r_s, r_hr;
  logic         r_zero, r_ovf, r_valid;
  logic [7:0]   r_op_count;

  logic [W-1:0] w_a, w_b, w_alu;
  logic         w_alu_ovf;

  always_comb begin
    w_a = x_in;
    case (M0)
      SEL_XIN: w_a = x_in;
      SEL_X:   w_a = r_x;
      SEL_S:   w_a = r_s;
      default: w_a = r_hr;
    endcase
  end

  always_comb begin
    w_b = r_x;
    case (M1)
      SELB_X:  w_b = r_x;
      SELB_C0: w_b = c_c0;
      SELB_C1: w_b = c_c1;
      default: w_b = r_s;
    endcase
  end

  bo_alu #(.W(W)) u_alu (
    .i_a   (w_a),
    .i_b   (w_b),
    .i_op  (M2),
    .o_y   (w_alu),
    .o_ovf (w_alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x        <= '0;
      r_s        <= '0;
      r_hr       <= '0;
      r_zero     <= 1'b1;
      r_ovf      <= 1'b0;
      r_valid    <= 1'b0;
      r_op_count <= 8'd0;
    end else begin
      if (LX) r_x <= x_in;
      if (LS) r_s <= w_alu;
      if (LH) r_hr <= H ? w_alu : r_s;
      if (LS) r_zero <= (w_alu == '0);
      r_valid <= LS;
      // LX opens a new computation, so the sticky flag and counter restart.
      if (LX) begin
        r_ovf      <= LS & w_alu_ovf;
        r_op_count <= LS ? 8'd1 : 8'd0;
      end else if (LS) begin
        r_ovf      <= r_ovf | w_alu_ovf;
        r_op_count <= (r_op_count == 8'hFF) ? 8'hFF : r_op_count + 8'd1;
      end
    end
  end

  assign result   = r_s;
  assign zero     = r_zero;
  assign ovf      = r_ovf;
  assign valid    = r_valid;
  assign op_count = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_bo_datapath.sv
// ============================================================================
// Module   : tb_bo_datapath
// Brief    : Directed self-checking bench for bo_datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bo_datapath;
  import bc_bo_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x_in;
  logic       LX, LS, LH, H;
  logic [1:0] M0, M1, M2;
  logic [7:0] result;
  logic       zero, ovf, valid;
  logic [7:0] op_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bo_datapath #(.W(8), .C0(2), .C1(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .x_in     (x_in),
    .LX       (LX),
    .LS       (LS),
    .LH       (LH),
    .H        (H),
    .M0       (M0),
    .M1       (M1),
    .M2       (M2),
    .result   (result),
    .zero     (zero),
    .ovf      (ovf),
    .valid    (valid),
    .op_count (op_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one control word, clock it in, and settle just after the edge.
  task automatic apply(input logic lx, input logic ls, input logic lh, input logic h,
                       input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                       input logic [7:0] xv);
    LX = lx; LS = ls; LH = lh; H = h; M0 = m0; M1 = m1; M2 = m2; x_in = xv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd0);
  endtask

  // BC steps A..E of the reference sequence.
  task automatic bc(input int s, input logic [7:0] xv);
    case (s)
      0: apply(1, 0, 1, 1, SEL_XIN, SELB_X,  OP_PASS, xv);
      1: apply(0, 1, 0, 0, SEL_X,   SELB_X,  OP_MUL,  8'd0);
      2: apply(0, 0, 1, 0, SEL_X,   SELB_X,  OP_PASS, 8'd0);
      3: apply(0, 1, 0, 0, SEL_X,   SELB_C1, OP_MUL,  8'd0);
      default: apply(0, 1, 0, 0, SEL_HR, SELB_X, OP_SUB, 8'd0);
    endcase
  endtask

  initial begin
    reset = 1'b1;
    LX = 1; LS = 1; LH = 1; H = 1; M0 = 2'd3; M1 = 2'd2; M2 = 2'd1; x_in = 8'hAA;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_result", result, 8'd0);
    chk("rst_zero", {7'd0, zero}, 8'd1);
    chk("rst_ovf", {7'd0, ovf}, 8'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_opcnt", op_count, 8'd0);
    reset = 1'b0;

    apply(0, 1, 0, 0, SEL_X, SELB_X, OP_PASS, 8'd77);
    chk("rst_x", result, 8'd0);
    apply(0, 1, 0, 0, SEL_HR, SELB_X, OP_PASS, 8'd77);
    chk("rst_hr", result, 8'd0);

    // Reference sequence, x_in = 3
    bc(0, 8'd3);
    chk("A_opcnt", op_count, 8'd0);
    chk("A_valid", {7'd0, valid}, 8'd0);
    bc(1, 8'd0);
    chk("B_s", result, 8'd9);
    chk("B_valid", {7'd0, valid}, 8'd1);
    bc(2, 8'd0);
    chk("C_valid", {7'd0, valid}, 8'd0);
    bc(3, 8'd0);
    chk("D_s", result, 8'd15);
    chk("D_valid", {7'd0, valid}, 8'd1);
    bc(4, 8'd0);
    chk("E_s", result, 8'd6);
    chk("E_valid", {7'd0, valid}, 8'd1);
    idle();
    chk("F_result", result, 8'd6);
    chk("F_opcnt", op_count, 8'd3);
    chk("F_ovf", {7'd0, ovf}, 8'd0);
    chk("F_zero", {7'd0, zero}, 8'd0);
    chk("F_valid", {7'd0, valid}, 8'd0);

    // Overflow sequence, x_in = 20
    bc(0, 8'd20);
    bc(1, 8'd0);
    chk("ovB_s", result, 8'd144);
    chk("ovB_ovf", {7'd0, ovf}, 8'd1);
    bc(2, 8'd0);
    bc(3, 8'd0);
    chk("ovD_s", result, 8'd100);
    bc(4, 8'd0);
    chk("ovE_s", result, 8'd124);
    idle();
    chk("ovF_ovf", {7'd0, ovf}, 8'd1);
    chk("ovF_opcnt", op_count, 8'd3);
    apply(1, 0, 0, 0, SEL_XIN, SELB_X, OP_PASS, 8'd7);
    chk("lx_ovf_clr", {7'd0, ovf}, 8'd0);
    chk("lx_opcnt_clr", op_count, 8'd0);

    // LX and LS together: ALU sees the old X
    apply(1, 1, 0, 0, SEL_X, SELB_C0, OP_ADD, 8'd9);
    chk("lxls_s", result, 8'd9);
    chk("lxls_opcnt", op_count, 8'd1);
    apply(0, 1, 0, 0, SEL_X, SELB_X, OP_PASS, 8'd0);
    chk("lxls_newx", result, 8'd9);
    apply(1, 1, 0, 0, SEL_XIN, SELB_C1, OP_MUL, 8'd200);
    chk("lxls_mul_s", result, 8'd232);
    chk("lxls_mul_ovf", {7'd0, ovf}, 8'd1);
    chk("lxls_mul_cnt", op_count, 8'd1);

    // Subtract borrow: X=3, HR=2
    apply(1, 0, 1, 1, SEL_XIN, SELB_X, OP_PASS, 8'd2);
    apply(1, 0, 0, 0, SEL_XIN, SELB_X, OP_PASS, 8'd3);
    chk("bor_ovf_pre", {7'd0, ovf}, 8'd0);
    apply(0, 1, 0, 0, SEL_HR, SELB_X, OP_SUB, 8'd0);
    chk("bor_s", result, 8'd255);
    chk("bor_ovf", {7'd0, ovf}, 8'd1);
    chk("bor_zero", {7'd0, zero}, 8'd0);

    // Zero flag then idle hold
    apply(1, 0, 0, 0, SEL_XIN, SELB_X, OP_PASS, 8'd5);
    apply(0, 1, 0, 0, SEL_X, SELB_X, OP_SUB, 8'd0);
    chk("z_s", result, 8'd0);
    chk("z_zero", {7'd0, zero}, 8'd1);
    idle();
    chk("idle_s", result, 8'd0);
    chk("idle_zero", {7'd0, zero}, 8'd1);
    chk("idle_valid", {7'd0, valid}, 8'd0);

    // Add carry, and S as operand B with sticky ovf
    apply(1, 0, 0, 0, SEL_XIN, SELB_X, OP_PASS, 8'd200);
    apply(0, 1, 0, 0, SEL_XIN, SELB_X, OP_ADD, 8'd100);
    chk("add_s", result, 8'd44);
    chk("add_ovf", {7'd0, ovf}, 8'd1);
    apply(0, 1, 0, 0, SEL_X, SELB_S, OP_ADD, 8'd0);
    chk("adds_s", result, 8'd244);
    chk("adds_ovf", {7'd0, ovf}, 8'd1);
    chk("adds_cnt", op_count, 8'd2);

    // Reset during step D
    bc(0, 8'd3);
    bc(1, 8'd0);
    bc(2, 8'd0);
    reset = 1'b1;
    bc(3, 8'd0);
    chk("mrst_s", result, 8'd0);
    chk("mrst_zero", {7'd0, zero}, 8'd1);
    chk("mrst_ovf", {7'd0, ovf}, 8'd0);
    chk("mrst_valid", {7'd0, valid}, 8'd0);
    chk("mrst_cnt", op_count, 8'd0);
    reset = 1'b0;
    apply(1, 0, 0, 0, SEL_XIN, SELB_X, OP_PASS, 8'd11);
    apply(0, 1, 0, 0, SEL_X, SELB_X, OP_PASS, 8'd0);
    chk("mrst_lx", result, 8'd11);
    chk("mrst_lx_cnt", op_count, 8'd1);

    // op_count saturation
    for (int i = 0; i < 258; i++) apply(0, 1, 0, 0, SEL_X, SELB_X, OP_PASS, 8'd0);
    chk("sat_cnt", op_count, 8'd255);
    chk("sat_valid", {7'd0, valid}, 8'd1);
    apply(1, 0, 0, 0, SEL_XIN, SELB_X, OP_PASS, 8'd1);
    chk("sat_clr", op_count, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
